// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 demultiplexer: slot state encoding and default sizes.
// Optional per-output transfer counters are enabled with DEMUX_STATS_EN.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake; refills in the same cycle it drains.
// With DEMUX_STATS_EN defined it also counts completed drains (wrapping).
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     din,
    input  logic                 take,
    output logic                 room,
    output logic                 valid,
    output logic [WIDTH-1:0]     data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] count
`endif
);

    slot_state_t state;
    logic        drain;

    assign valid = (state == FULL);
    assign drain = valid && take;
    // A full slot can still take a new item when its consumer empties it this cycle.
    assign room  = (state == EMPTY) || take;

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            // NOTE: data is cleared on reset because consumers may observe it while valid is low.
            data  <= '0;
        end else begin
            if (load) begin
                state <= FULL;
                data  <= din;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (drain) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux1n2_4bit.sv
// Registered 1-to-2 demultiplexer: steers the producer stream into one of two holding slots by Sel.
// Define DEMUX_STATS_EN to expose per-output transfer counters.
module demux1n2_4bit
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    input  logic [WIDTH-1:0]     InData,
    input  logic                 Sel,
    output logic                 InReady,
    output logic                 Out0Valid,
    output logic [WIDTH-1:0]     Out0Data,
    input  logic                 Out0Ready,
    output logic                 Out1Valid,
    output logic [WIDTH-1:0]     Out1Data,
    input  logic                 Out1Ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] Out0Count,
    output logic [CNT_WIDTH-1:0] Out1Count
`endif
);

    logic room0;
    logic room1;
    logic accept;

    // Only the selected slot gates the producer; held low while reset is asserted.
    assign InReady = Reset && (Sel ? room1 : room0);
    assign accept  = InValid && InReady;

    demux_slot #(
        .WIDTH    (WIDTH)
`ifdef DEMUX_STATS_EN
        ,
        .CNT_WIDTH(CNT_WIDTH)
`endif
    ) u_slot0 (
        .clk  (Clock),
        .rst_n(Reset),
        .load (accept && !Sel),
        .din  (InData),
        .take (Out0Ready),
        .room (room0),
        .valid(Out0Valid),
        .data (Out0Data)
`ifdef DEMUX_STATS_EN
        ,
        .count(Out0Count)
`endif
    );

    demux_slot #(
        .WIDTH    (WIDTH)
`ifdef DEMUX_STATS_EN
        ,
        .CNT_WIDTH(CNT_WIDTH)
`endif
    ) u_slot1 (
        .clk  (Clock),
        .rst_n(Reset),
        .load (accept && Sel),
        .din  (InData),
        .take (Out1Ready),
        .room (room1),
        .valid(Out1Valid),
        .data (Out1Data)
`ifdef DEMUX_STATS_EN
        ,
        .count(Out1Count)
`endif
    );

endmodule

// File: doc/demux1n2_4bit.md
# demux1n2_4bit

Registered 1-to-2 demultiplexer for 4-bit fields: steers one producer stream to one of two consumers chosen by `Sel`, the write-side counterpart of the 2-to-1 select muxes in the datapath. Each output owns a one-entry holding slot with a valid/ready handshake, so either consumer may stall without losing data or blocking the other path's drain. Sits between the control-field producer and the two destination units of the 24-bit single-cycle CPU.

## Interface
- `WIDTH`, 4: data width in bits.
- `CNT_WIDTH`, 8: width of per-output transfer counters (only with stats enabled).

- `Clock`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-low reset
- `InValid`  in  1  producer has data
- `InData`  in  WIDTH  producer data
- `Sel`  in  1  destination: 0 → Out0, 1 → Out1; sampled only on accept
- `InReady`  out  1  demux accepts this cycle
- `Out0Valid` / `Out1Valid`  out  1  slot holds data
- `Out0Data` / `Out1Data`  out  WIDTH  slot data
- `Out0Ready` / `Out1Ready`  in  1  consumer takes data
- `Out0Count` / `Out1Count`  out  CNT_WIDTH  completed transfers per output (stats only)

## Operation
- Accept: `InValid && InReady`. Drain on output k: `OutkValid && OutkReady`.
- Per-slot states: EMPTY, FULL. `OutkValid` = (state == FULL).
- `InReady` (combinational) = slot[Sel] EMPTY, or slot[Sel] FULL and `Out[Sel]Ready` high. Never depends on the unselected slot.
- EMPTY → FULL on accept with Sel = k; data captured.
- FULL → EMPTY on drain with no accept into k.
- FULL → FULL on drain and accept in the same cycle: new data replaces old, no bubble.
- FULL with no drain: data and valid held stable; `InReady` low while Sel points at it.
- Unselected slot drains independently in the same cycle as an accept into the other.
- `InData`/`Sel` ignored when `InValid` low; `Sel` may change freely while not accepting.
- Data registers update only on accept into that slot.

## Timing
- Latency: accept at edge N → `OutkValid` high and `OutkData` valid after edge N, i.e. one cycle.
- Throughput: one transfer per cycle per output under continuous ready.
- Reset (sampled on `Clock` edge with `Reset` low): both slots EMPTY, `Out0Valid`=`Out1Valid`=0, `Out0Data`=`Out1Data`=0, counters 0. Reset wins over simultaneous accept/drain; held data discarded mid-operation.
- `InReady` low during reset cycle regardless of inputs.

## Configuration
- `DEMUX_STATS_EN` defined: `Out0Count`/`Out1Count` present; each increments by 1 per drain on its output, wraps 2^CNT_WIDTH−1 → 0, cleared by reset.
- Not defined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared package `demux_pkg`: slot state encoding (EMPTY = 1'b0, FULL = 1'b1), default `WIDTH` and `CNT_WIDTH` constants.
- Sub-module `demux_slot`: one-entry holding register with state, data, accept/drain logic and optional counter; instantiated twice. Top contains only `Sel` decoding and `InReady`.

## Test plan
- Reset: drive Reset=0 with InValid=1 → next cycle both valids 0, data 0, InReady 0; counters 0.
- Single routes: accept 4'hA with Sel=0, then 4'h5 with Sel=1, both readys high → Out0Data=4'hA one cycle after accept, Out1Data=4'h5 next cycle; Out0Count=Out1Count=1.
- Backpressure: Out0Ready=0, accept 4'h3 Sel=0 → Out0 holds 4'h3; next InValid Sel=0 sees InReady=0; Sel=1 with 4'h7 accepted and appears on Out1 while Out0 stays 4'h3.
- Flow-through: Out0 FULL with 4'h1, Out0Ready=1, accept 4'h2 Sel=0 same cycle → Out0Valid stays 1, Out0Data=4'h2, no lost or duplicated item.
- Counter wrap (stats on): 256 drains on Out1 with CNT_WIDTH=8 → Out1Count returns to 0.
- Mid-operation reset: both slots FULL, assert Reset → both valids 0 next cycle, later accept 4'hF Sel=1 delivered normally.
